// File: rtl/reflet_bus_arbiter.sv
// Two-master round-robin arbiter for a single-port, synchronous-read memory bus.
// Grants are combinational from registered ownership state; read-valid tags follow one cycle later.
module reflet_bus_arbiter #(
    parameter int wordsize = 16,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m0_req,
    input  logic [wordsize-1:0] m0_addr,
    input  logic [wordsize-1:0] m0_wdata,
    input  logic                m0_we,
    output logic                m0_gnt,
    output logic [wordsize-1:0] m0_rdata,
    output logic                m0_rvalid,
    input  logic                m1_req,
    input  logic [wordsize-1:0] m1_addr,
    input  logic [wordsize-1:0] m1_wdata,
    input  logic                m1_we,
    output logic                m1_gnt,
    output logic [wordsize-1:0] m1_rdata,
    output logic                m1_rvalid,
    output logic [wordsize-1:0] mem_addr,
    output logic [wordsize-1:0] mem_wdata,
    output logic                mem_we,
    output logic                mem_en,
    input  logic [wordsize-1:0] mem_rdata
);
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {NONE = 2'd0, M0 = 2'd1, M1 = 2'd2} owner_t;

    owner_t        owner;
    logic          rr_ptr;      // 0 favours m0 on a tie, 1 favours m1
    logic [HW-1:0] hold_cnt;
    logic          rv0, rv1;
    logic          g0, g1;
    logic          hold_ok;

    always_comb begin
        g0      = 1'b0;
        g1      = 1'b0;
        hold_ok = (hold_cnt < HOLD_MAX);
        case (owner)
            M0: begin
                if (m0_req && (!m1_req || hold_ok)) g0 = 1'b1;
                else if (m1_req)                    g1 = 1'b1;
            end
            M1: begin
                if (m1_req && (!m0_req || hold_ok)) g1 = 1'b1;
                else if (m0_req)                    g0 = 1'b1;
            end
            default: begin
                if (m0_req && m1_req) begin
                    g0 = ~rr_ptr;
                    g1 = rr_ptr;
                end else begin
                    g0 = m0_req;
                    g1 = m1_req;
                end
            end
        endcase
        // Reset silences the bus even though state only clears on the edge.
        if (reset) begin
            g0 = 1'b0;
            g1 = 1'b0;
        end
    end

    assign m0_gnt    = g0;
    assign m1_gnt    = g1;
    assign mem_en    = g0 | g1;
    assign mem_we    = g0 ? m0_we    : (g1 ? m1_we    : 1'b0);
    assign mem_addr  = g0 ? m0_addr  : (g1 ? m1_addr  : '0);
    assign mem_wdata = g0 ? m0_wdata : (g1 ? m1_wdata : '0);

    assign m0_rvalid = rv0 & ~reset;
    assign m1_rvalid = rv1 & ~reset;
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner    <= NONE;
            rr_ptr   <= 1'b0;
            hold_cnt <= '0;
            rv0      <= 1'b0;
            rv1      <= 1'b0;
        end else begin
            rv0 <= g0 & ~m0_we;
            rv1 <= g1 & ~m1_we;
            if (g0 | g1) begin
                owner  <= g0 ? M0 : M1;
                rr_ptr <= g0;
                if ((g0 && owner == M0) || (g1 && owner == M1))
                    hold_cnt <= (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
                else
                    hold_cnt <= '0;
            end else begin
                owner    <= NONE;
                hold_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_reflet_bus_arbiter.sv
// Bench for reflet_bus_arbiter: two instances (MAX_HOLD=4 and MAX_HOLD=1) share master stimulus,
// each backed by a synchronous-read memory model; read data is tracked in per-master queues.
module tb_reflet_bus_arbiter;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [W-1:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;

    logic         a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid, a_mem_we, a_mem_en;
    logic [W-1:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_wdata;
    logic [W-1:0] a_mem_rdata = '0;
    logic         b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_mem_we, b_mem_en;
    logic [W-1:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata;
    logic [W-1:0] b_mem_rdata = '0;

    int total = 0;
    int bad = 0;
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];

    always #5 clk = ~clk;

    reflet_bus_arbiter #(.wordsize(W), .MAX_HOLD(4)) dut_a (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
        .m0_gnt(a_m0_gnt), .m0_rdata(a_m0_rdata), .m0_rvalid(a_m0_rvalid),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
        .m1_gnt(a_m1_gnt), .m1_rdata(a_m1_rdata), .m1_rvalid(a_m1_rvalid),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we),
        .mem_en(a_mem_en), .mem_rdata(a_mem_rdata)
    );

    reflet_bus_arbiter #(.wordsize(W), .MAX_HOLD(1)) dut_b (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
        .m0_gnt(b_m0_gnt), .m0_rdata(b_m0_rdata), .m0_rvalid(b_m0_rvalid),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
        .m1_gnt(b_m1_gnt), .m1_rdata(b_m1_rdata), .m1_rvalid(b_m1_rvalid),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
        .mem_en(b_mem_en), .mem_rdata(b_mem_rdata)
    );

    function automatic logic [W-1:0] mf(input logic [W-1:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    always @(posedge clk) begin
        if (a_mem_en && !a_mem_we) a_mem_rdata <= mf(a_mem_addr);
        if (b_mem_en && !b_mem_we) b_mem_rdata <= mf(b_mem_addr);
    end

    // Drive one cycle just after the rising edge, return at the falling edge for sampling.
    task automatic cyc(input logic rst,
                       input logic r0, input logic [W-1:0] a0, input logic we0, input logic [W-1:0] wd0,
                       input logic r1, input logic [W-1:0] a1, input logic we1, input logic [W-1:0] wd1);
        @(posedge clk);
        #1;
        reset = rst;
        m0_req = r0; m0_addr = a0; m0_we = we0; m0_wdata = wd0;
        m1_req = r1; m1_addr = a1; m1_we = we1; m1_wdata = wd1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cyc(1, 1, 16'h1111, 1, 16'h2222, 1, 16'h3333, 0, 16'h4444);
            total++;
            if ({a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid, a_mem_en, a_mem_we} !== 6'b0) begin
                bad++;
                $display("FAIL reset_ctrl cyc=%0d got=%b exp=000000", i,
                         {a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid, a_mem_en, a_mem_we});
            end
            total++;
            if (a_mem_addr !== 16'h0 || a_mem_wdata !== 16'h0) begin
                bad++;
                $display("FAIL reset_bus cyc=%0d addr=%h wdata=%h exp=0", i, a_mem_addr, a_mem_wdata);
            end
        end
    endtask

    task automatic test_single_reads();
        logic pv;
        logic [W-1:0] e, ad;
        pv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic rq;
            rq = (i < 3);
            ad = 16'(16'h0010 + 2 * i);
            cyc(0, rq, ad, 0, 16'h0, 0, 16'h0, 0, 16'h0);
            total++;
            if (a_m0_gnt !== rq || a_m1_gnt !== 1'b0) begin
                bad++;
                $display("FAIL single_gnt cyc=%0d got=%b%b exp=%b0", i, a_m0_gnt, a_m1_gnt, rq);
            end
            if (rq) begin
                total++;
                if (a_mem_addr !== ad || a_mem_en !== 1'b1) begin
                    bad++;
                    $display("FAIL single_addr cyc=%0d got=%h en=%b exp=%h", i, a_mem_addr, a_mem_en, ad);
                end
            end
            total++;
            if (a_m0_rvalid !== pv || a_m1_rvalid !== 1'b0) begin
                bad++;
                $display("FAIL single_rvalid cyc=%0d got=%b%b exp=%b0", i, a_m0_rvalid, a_m1_rvalid, pv);
            end
            if (pv) begin
                e = q0.pop_front();
                total++;
                if (a_m0_rdata !== e) begin
                    bad++;
                    $display("FAIL single_rdata cyc=%0d got=%h exp=%h", i, a_m0_rdata, e);
                end
            end
            if (rq) q0.push_back(mf(ad));
            pv = rq;
        end
    endtask

    task automatic test_contention();
        logic pv0, pv1;
        logic [W-1:0] e;
        cyc(1, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        pv0 = 1'b0; pv1 = 1'b0;
        for (int i = 0; i < 13; i++) begin
            logic rq, e0, e1;
            rq = (i < 12);
            e0 = rq && ((i / 4) % 2 == 0);
            e1 = rq && !e0;
            cyc(0, rq, 16'(16'h0100 + i), 0, 16'h0, rq, 16'(16'h0200 + i), 0, 16'h0);
            total++;
            if (a_m0_gnt !== e0 || a_m1_gnt !== e1) begin
                bad++;
                $display("FAIL contention_gnt cyc=%0d got=%b%b exp=%b%b", i, a_m0_gnt, a_m1_gnt, e0, e1);
            end
            total++;
            if (a_mem_en !== rq) begin
                bad++;
                $display("FAIL contention_en cyc=%0d got=%b exp=%b", i, a_mem_en, rq);
            end
            total++;
            if (a_m0_rvalid !== pv0 || a_m1_rvalid !== pv1) begin
                bad++;
                $display("FAIL contention_rvalid cyc=%0d got=%b%b exp=%b%b", i, a_m0_rvalid, a_m1_rvalid, pv0, pv1);
            end
            if (pv0) begin
                e = q0.pop_front();
                total++;
                if (a_m0_rdata !== e) begin
                    bad++;
                    $display("FAIL contention_rdata0 cyc=%0d got=%h exp=%h", i, a_m0_rdata, e);
                end
            end
            if (pv1) begin
                e = q1.pop_front();
                total++;
                if (a_m1_rdata !== e) begin
                    bad++;
                    $display("FAIL contention_rdata1 cyc=%0d got=%h exp=%h", i, a_m1_rdata, e);
                end
            end
            if (e0) q0.push_back(mf(16'(16'h0100 + i)));
            if (e1) q1.push_back(mf(16'(16'h0200 + i)));
            pv0 = e0; pv1 = e1;
        end
    endtask

    task automatic test_alternation();
        logic pv0, pv1;
        logic [W-1:0] e;
        cyc(1, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        pv0 = 1'b0; pv1 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            logic rq, e0, e1;
            rq = (i < 8);
            e0 = rq && (i % 2 == 0);
            e1 = rq && !e0;
            cyc(0, rq, 16'(16'h0300 + i), 0, 16'h0, rq, 16'(16'h0400 + i), 0, 16'h0);
            total++;
            if (b_m0_gnt !== e0 || b_m1_gnt !== e1) begin
                bad++;
                $display("FAIL alt_gnt cyc=%0d got=%b%b exp=%b%b", i, b_m0_gnt, b_m1_gnt, e0, e1);
            end
            total++;
            if (b_m0_rvalid !== pv0 || b_m1_rvalid !== pv1) begin
                bad++;
                $display("FAIL alt_rvalid cyc=%0d got=%b%b exp=%b%b", i, b_m0_rvalid, b_m1_rvalid, pv0, pv1);
            end
            if (pv0) begin
                e = q0.pop_front();
                total++;
                if (b_m0_rdata !== e) begin
                    bad++;
                    $display("FAIL alt_rdata0 cyc=%0d got=%h exp=%h", i, b_m0_rdata, e);
                end
            end
            if (pv1) begin
                e = q1.pop_front();
                total++;
                if (b_m1_rdata !== e) begin
                    bad++;
                    $display("FAIL alt_rdata1 cyc=%0d got=%h exp=%h", i, b_m1_rdata, e);
                end
            end
            if (e0) q0.push_back(mf(16'(16'h0300 + i)));
            if (e1) q1.push_back(mf(16'(16'h0400 + i)));
            pv0 = e0; pv1 = e1;
        end
    endtask

    task automatic test_write();
        cyc(1, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        cyc(0, 0, 16'h0, 0, 16'h0, 1, 16'h0020, 1, 16'hBEEF);
        total++;
        if (a_m1_gnt !== 1'b1 || a_m0_gnt !== 1'b0 || a_mem_we !== 1'b1 || a_mem_en !== 1'b1) begin
            bad++;
            $display("FAIL write_ctrl got gnt=%b%b we=%b en=%b exp gnt=01 we=1 en=1",
                     a_m0_gnt, a_m1_gnt, a_mem_we, a_mem_en);
        end
        total++;
        if (a_mem_addr !== 16'h0020 || a_mem_wdata !== 16'hBEEF) begin
            bad++;
            $display("FAIL write_bus got addr=%h wdata=%h exp addr=0020 wdata=beef", a_mem_addr, a_mem_wdata);
        end
        cyc(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        total++;
        if (a_m0_rvalid !== 1'b0 || a_m1_rvalid !== 1'b0 || a_mem_en !== 1'b0 || a_mem_we !== 1'b0) begin
            bad++;
            $display("FAIL write_after got rvalid=%b%b en=%b we=%b exp all 0",
                     a_m0_rvalid, a_m1_rvalid, a_mem_en, a_mem_we);
        end
        total++;
        if (a_mem_addr !== 16'h0 || a_mem_wdata !== 16'h0) begin
            bad++;
            $display("FAIL idle_bus got addr=%h wdata=%h exp 0", a_mem_addr, a_mem_wdata);
        end
    endtask

    task automatic test_rr_tie();
        cyc(1, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        cyc(0, 0, 16'h0, 0, 16'h0, 1, 16'h0044, 0, 16'h0);
        total++;
        if (a_m1_gnt !== 1'b1) begin
            bad++;
            $display("FAIL rr_m1_alone got=%b exp=1", a_m1_gnt);
        end
        cyc(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        cyc(0, 1, 16'h0050, 0, 16'h0, 1, 16'h0052, 0, 16'h0);
        total++;
        if (a_m0_gnt !== 1'b1 || a_m1_gnt !== 1'b0) begin
            bad++;
            $display("FAIL rr_tie_m0 got=%b%b exp=10", a_m0_gnt, a_m1_gnt);
        end
        cyc(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        cyc(0, 1, 16'h0060, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        cyc(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        cyc(0, 1, 16'h0070, 0, 16'h0, 1, 16'h0072, 0, 16'h0);
        total++;
        if (a_m0_gnt !== 1'b0 || a_m1_gnt !== 1'b1) begin
            bad++;
            $display("FAIL rr_tie_m1 got=%b%b exp=01", a_m0_gnt, a_m1_gnt);
        end
        cyc(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    endtask

    task automatic test_reset_drop();
        cyc(1, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        cyc(0, 1, 16'h0030, 0, 16'h0, 0, 16'h0, 0, 16'h0);
        total++;
        if (a_m0_gnt !== 1'b1 || a_mem_addr !== 16'h0030) begin
            bad++;
            $display("FAIL rdrop_gnt got gnt=%b addr=%h exp gnt=1 addr=0030", a_m0_gnt, a_mem_addr);
        end
        cyc(1, 1, 16'h0032, 0, 16'h0, 1, 16'h0034, 1, 16'h5555);
        total++;
        if ({a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid, a_mem_en, a_mem_we} !== 6'b0 ||
            a_mem_addr !== 16'h0 || a_mem_wdata !== 16'h0) begin
            bad++;
            $display("FAIL rdrop_reset got ctrl=%b addr=%h wdata=%h exp all 0",
                     {a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid, a_mem_en, a_mem_we}, a_mem_addr, a_mem_wdata);
        end
        cyc(0, 1, 16'h0036, 0, 16'h0, 1, 16'h0038, 0, 16'h0);
        total++;
        if (a_m0_gnt !== 1'b1 || a_m1_gnt !== 1'b0 || a_m0_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL rdrop_after got gnt=%b%b rvalid0=%b exp gnt=10 rvalid0=0",
                     a_m0_gnt, a_m1_gnt, a_m0_rvalid);
        end
        cyc(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 16'h0);
    endtask

    initial begin
        test_reset();
        test_single_reads();
        test_contention();
        test_alternation();
        test_write();
        test_rr_tie();
        test_reset_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
